// File: rtl/wave_capture_pkg.sv
// Shared types and constants for the wave capture engine.
package wave_capture_pkg;

    // Capture FSM encoding; 2'b11 is never entered and falls back to ST_ARMED.
    typedef enum logic [1:0] {
        ST_ARMED   = 2'b00,
        ST_ACTIVE  = 2'b01,
        ST_WAIT    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    // Trigger mode selector values; 2'd3 behaves as rising.
    localparam logic [1:0] TRIG_RISE = 2'd0;
    localparam logic [1:0] TRIG_FALL = 2'd1;
    localparam logic [1:0] TRIG_FREE = 2'd2;

endpackage

// File: rtl/wave_capture_trig_if.sv
// Sample stream in, display RAM write port out.
//
// Handshake: new_sample_ready is a one-cycle strobe qualifying new_sample_in;
// there is no ready/backpressure, the engine consumes every strobed sample.
// write_enable is a one-cycle strobe qualifying write_address/write_sample;
// the RAM must accept every write. Address/data hold their last value when
// write_enable is low.
interface wave_capture_trig_if #(
    parameter int SAMPLE_W = 16,
    parameter int OUT_W    = 8,
    parameter int ADDR_W   = 8
);
    logic                new_sample_ready;
    logic [SAMPLE_W-1:0] new_sample_in;
    logic                write_enable;
    logic [ADDR_W:0]     write_address;
    logic [OUT_W-1:0]    write_sample;

    // Codec/RAM side: sources samples, sinks RAM writes.
    modport master (
        output new_sample_ready,
        output new_sample_in,
        input  write_enable,
        input  write_address,
        input  write_sample
    );

    // Capture engine side.
    modport slave (
        input  new_sample_ready,
        input  new_sample_in,
        output write_enable,
        output write_address,
        output write_sample
    );
endinterface

// File: rtl/wave_trig_detect.sv
// Combinational signed level/slope trigger compare.
module wave_trig_detect
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic signed [SAMPLE_W-1:0] prev_sample,
    input  logic signed [SAMPLE_W-1:0] cur_sample,
    input  logic signed [SAMPLE_W-1:0] trig_level,
    input  logic [1:0]                 trig_mode,
    output logic                       hit
);

    // Select the crossing test for the current mode; unknown modes act as rising.
    always_comb begin
        hit = 1'b0;
        case (trig_mode)
            TRIG_FALL: hit = (prev_sample >= trig_level) && (cur_sample < trig_level);
            TRIG_FREE: hit = 1'b1;
            default:   hit = (prev_sample < trig_level) && (cur_sample >= trig_level);
        endcase
    end

endmodule

// File: rtl/wave_capture_trig.sv
// Triggered, decimated capture into the bank of a double-buffered display RAM
// that the display is not reading; flips banks once the display goes idle.
module wave_capture_trig
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W     = 16,
    parameter int OUT_W        = 8,
    parameter int ADDR_W       = 8,
    parameter int DECIM_W      = 4,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    wave_capture_trig_if.slave         bus,
    input  logic                       wave_display_idle,
    input  logic                       capture_en,
    input  logic [1:0]                 trig_mode,
    input  logic signed [SAMPLE_W-1:0] trig_level,
    input  logic [DECIM_W-1:0]         decim,
    output logic                       read_index,
    output logic                       frame_done,
    output logic                       auto_triggered,
    output logic                       armed,
    output state_t                     state_dbg
);

    // Timeout counter only needs to reach AUTO_TIMEOUT-1.
    localparam int TO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((AUTO_TIMEOUT > 0) ? AUTO_TIMEOUT - 1 : 0);
    localparam bit TO_ENABLED = (AUTO_TIMEOUT > 0);

    state_t state, state_nxt;

    logic                       sample_stb;
    logic signed [SAMPLE_W-1:0] cur_sample;
    logic signed [SAMPLE_W-1:0] prev_sample;
    logic [ADDR_W-1:0]          index;
    logic [DECIM_W-1:0]         dcnt;
    logic [DECIM_W-1:0]         decim_l;
    logic [TO_W-1:0]            timeout_cnt;

    logic trig_hit;
    logic natural_hit;
    logic timeout_hit;
    logic fire;
    logic store;
    logic last_store;

    logic              wr_en_q;
    logic [ADDR_W:0]   wr_addr_q;
    logic [OUT_W-1:0]  wr_data_q;

    assign sample_stb = bus.new_sample_ready;
    assign cur_sample = bus.new_sample_in;
    assign state_dbg  = state;

    wave_trig_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_detect (
        .prev_sample (prev_sample),
        .cur_sample  (cur_sample),
        .trig_level  (trig_level),
        .trig_mode   (trig_mode),
        .hit         (trig_hit)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_ARMED;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: trigger starts a frame, last store ends it, idle re-arms.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARMED:  if (fire) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (last_store) state_nxt = ST_WAIT;
            ST_WAIT:   if (wave_display_idle) state_nxt = ST_ARMED;
            default:   state_nxt = ST_ARMED;
        endcase
    end

    // FSM outputs and per-cycle control decodes; a natural hit outranks the timeout.
    always_comb begin
        armed       = (state == ST_ARMED);
        natural_hit = sample_stb && capture_en && trig_hit;
        timeout_hit = TO_ENABLED && sample_stb && capture_en && !trig_hit
                      && (timeout_cnt == TO_LAST);
        fire        = armed && (natural_hit || timeout_hit);
        store       = fire || ((state == ST_ACTIVE) && sample_stb && (dcnt == '0));
        last_store  = (state == ST_ACTIVE) && store && (index == '1);
    end

    // Sample history, frame counters, bank select and trigger status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_sample    <= '0;
            index          <= '0;
            dcnt           <= '0;
            decim_l        <= '0;
            timeout_cnt    <= '0;
            read_index     <= 1'b0;
            auto_triggered <= 1'b0;
        end else begin
            if (sample_stb) prev_sample <= cur_sample;
            case (state)
                ST_ARMED: begin
                    if (fire) begin
                        // The trigger sample is stored at index 0 and is decimation slot 0.
                        index          <= ADDR_W'(1);
                        dcnt           <= (decim == '0) ? '0 : DECIM_W'(1);
                        decim_l        <= decim;
                        timeout_cnt    <= '0;
                        auto_triggered <= timeout_hit;
                    end else if (!capture_en) begin
                        timeout_cnt <= '0;
                    end else if (sample_stb) begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (sample_stb) begin
                        dcnt <= (dcnt == decim_l) ? '0 : dcnt + DECIM_W'(1);
                        if (store) index <= index + ADDR_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (wave_display_idle) begin
                        index       <= '0;
                        dcnt        <= '0;
                        timeout_cnt <= '0;
                        read_index  <= ~read_index;
                    end
                end
                default: begin
                    index       <= '0;
                    dcnt        <= '0;
                    timeout_cnt <= '0;
                end
            endcase
        end
    end

    // Registered RAM write port: sample MSBs in offset binary, into the unread bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_en_q    <= store;
            frame_done <= last_store;
            if (store) begin
                wr_addr_q <= {~read_index, index};
                wr_data_q <= {~cur_sample[SAMPLE_W-1], cur_sample[SAMPLE_W-2 -: OUT_W-1]};
            end
        end
    end

    assign bus.write_enable  = wr_en_q;
    assign bus.write_address = wr_addr_q;
    assign bus.write_sample  = wr_data_q;

endmodule

// File: tb/tb_wave_capture_trig.sv
// Directed testbench for wave_capture_trig (DEPTH 256, AUTO_TIMEOUT 16).
module tb_wave_capture_trig;
    import wave_capture_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic               wave_display_idle;
    logic               capture_en;
    logic [1:0]         trig_mode;
    logic signed [15:0] trig_level;
    logic [3:0]         decim;
    logic               read_index;
    logic               frame_done;
    logic               auto_triggered;
    logic               armed;
    state_t             state_dbg;

    wave_capture_trig_if #(.SAMPLE_W(16), .OUT_W(8), .ADDR_W(8)) bus ();

    wave_capture_trig #(
        .SAMPLE_W     (16),
        .OUT_W        (8),
        .ADDR_W       (8),
        .DECIM_W      (4),
        .AUTO_TIMEOUT (16)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .bus               (bus),
        .wave_display_idle (wave_display_idle),
        .capture_en        (capture_en),
        .trig_mode         (trig_mode),
        .trig_level        (trig_level),
        .decim             (decim),
        .read_index        (read_index),
        .frame_done        (frame_done),
        .auto_triggered    (auto_triggered),
        .armed             (armed),
        .state_dbg         (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];

    logic       o_we;
    logic       o_fd;
    logic [8:0] o_addr;
    logic [7:0] o_data;

    // ---------------- driver tasks ----------------
    // One strobe cycle; outputs are sampled on the following falling edge.
    task automatic send(input logic [15:0] val, input logic idle_now);
        @(negedge clk);
        bus.new_sample_ready = 1'b1;
        bus.new_sample_in    = val;
        wave_display_idle    = idle_now;
        @(negedge clk);
        bus.new_sample_ready = 1'b0;
        wave_display_idle    = 1'b0;
        o_we   = bus.write_enable;
        o_addr = bus.write_address;
        o_data = bus.write_sample;
        o_fd   = frame_done;
    endtask

    task automatic pulse_idle();
        @(negedge clk);
        wave_display_idle = 1'b1;
        @(negedge clk);
        wave_display_idle = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (armed !== 1'b1) begin n_err++; $display("FAIL reset_armed got=%b exp=1", armed); end
        n_cmp++; if (state_dbg !== ST_ARMED) begin n_err++; $display("FAIL reset_state got=%b exp=00", state_dbg); end
        n_cmp++; if (bus.write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b exp=0", bus.write_enable); end
        n_cmp++; if (bus.write_address !== 9'h000) begin n_err++; $display("FAIL reset_addr got=%h exp=000", bus.write_address); end
        n_cmp++; if (bus.write_sample !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", bus.write_sample); end
        n_cmp++; if ({read_index, frame_done, auto_triggered} !== 3'b000) begin
            n_err++; $display("FAIL reset_status got=%b exp=000", {read_index, frame_done, auto_triggered});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rising();
        trig_mode = TRIG_RISE; trig_level = 16'sd0; decim = 4'd0; capture_en = 1'b1;
        send(16'hFFFB, 1'b0);  // -5
        n_cmp++; if (o_we !== 1'b0) begin n_err++; $display("FAIL rise_pre_we got=%b exp=0", o_we); end
        send(16'h0003, 1'b0);
        n_cmp++; if ({o_we, o_addr, o_data} !== {1'b1, 9'h100, 8'h80}) begin
            n_err++; $display("FAIL rise_first got=%b/%h/%h exp=1/100/80", o_we, o_addr, o_data);
        end
        for (int i = 1; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send({b, 8'h00}, 1'b0);
            n_cmp++;
            if ({o_we, o_addr, o_data, o_fd} !== {1'b1, 9'h100 + 9'(i), b ^ 8'h80, (i == 255)}) begin
                n_err++; $display("FAIL rise_write[%0d] got=%b/%h/%h/%b exp=1/%h/%h/%b",
                                  i, o_we, o_addr, o_data, o_fd, 9'h100 + 9'(i), b ^ 8'h80, (i == 255));
            end
        end
        n_cmp++; if (state_dbg !== ST_WAIT) begin n_err++; $display("FAIL rise_wait_state got=%b exp=10", state_dbg); end
        send(16'h0000, 1'b0);
        n_cmp++; if (o_we !== 1'b0) begin n_err++; $display("FAIL rise_wait_nowrite got=%b exp=0", o_we); end
        pulse_idle();
        n_cmp++; if ({read_index, armed} !== 2'b11) begin
            n_err++; $display("FAIL rise_flip got=%b exp=11", {read_index, armed});
        end
    endtask

    task automatic test_falling();
        int bad;
        trig_mode = TRIG_FALL; trig_level = 16'sd1000;
        bad = 0;
        send(16'd900, 1'b0);  if (o_we) bad++;
        send(16'd1100, 1'b0); if (o_we) bad++;
        send(16'd1200, 1'b0); if (o_we) bad++;
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL fall_no_trig got=%0d exp=0", bad); end
        send(16'd900, 1'b0);
        n_cmp++; if ({o_we, o_addr, o_data} !== {1'b1, 9'h000, 8'h83}) begin
            n_err++; $display("FAIL fall_first got=%b/%h/%h exp=1/000/83", o_we, o_addr, o_data);
        end
        for (int i = 1; i < 256; i++) begin
            send(16'h0000, 1'b0);
            n_cmp++;
            if ({o_we, o_addr, o_data, o_fd} !== {1'b1, 9'(i), 8'h80, (i == 255)}) begin
                n_err++; $display("FAIL fall_write[%0d] got=%b/%h/%h/%b exp=1/%h/80/%b",
                                  i, o_we, o_addr, o_data, o_fd, 9'(i), (i == 255));
            end
        end
        pulse_idle();
        n_cmp++; if (read_index !== 1'b0) begin n_err++; $display("FAIL fall_flip got=%b exp=0", read_index); end
    endtask

    task automatic test_decim();
        int writes;
        trig_mode = TRIG_FREE; decim = 4'd3;
        writes = 0;
        for (int k = 0; k < 1024; k++) begin
            logic exp_we;
            int gap;
            exp_we = (k % 4 == 0);
            if (exp_we) exp_q.push_back({9'h100 + 9'(k / 4), 8'(k / 4) ^ 8'h80});
            send(16'(k * 64), 1'b0);
            n_cmp++;
            if (o_we !== exp_we) begin
                n_err++; $display("FAIL decim_we[%0d] got=%b exp=%b", k, o_we, exp_we);
            end
            if (o_we) writes++;
            if (exp_we && exp_q.size() > 0) begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if (o_we) begin
                    n_cmp++;
                    if ({o_addr, o_data} !== e) begin
                        n_err++; $display("FAIL decim_data[%0d] got=%h/%h exp=%h/%h", k, o_addr, o_data, e[16:8], e[7:0]);
                    end
                end
            end
            if (k == 1020) begin
                n_cmp++; if (o_fd !== 1'b1) begin n_err++; $display("FAIL decim_frame_done got=%b exp=1", o_fd); end
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                n_cmp++;
                if (bus.write_enable !== 1'b0) begin n_err++; $display("FAIL decim_gap_we[%0d] got=1 exp=0", k); end
            end
        end
        n_cmp++; if (writes !== 256) begin n_err++; $display("FAIL decim_count got=%0d exp=256", writes); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL decim_queue got=%0d exp=0", exp_q.size()); end
        pulse_idle();
        n_cmp++; if (read_index !== 1'b1) begin n_err++; $display("FAIL decim_flip got=%b exp=1", read_index); end
    endtask

    task automatic test_auto_timeout();
        int early;
        trig_mode = TRIG_RISE; trig_level = 16'sd100; decim = 4'd0;
        early = 0;
        for (int i = 0; i < 15; i++) begin
            send(16'h0000, 1'b0);
            if (o_we) early++;
        end
        n_cmp++; if (early !== 0) begin n_err++; $display("FAIL auto_early got=%0d exp=0", early); end
        send(16'h0000, 1'b0);
        n_cmp++; if ({o_we, o_addr, o_data, auto_triggered} !== {1'b1, 9'h000, 8'h80, 1'b1}) begin
            n_err++; $display("FAIL auto_fire got=%b/%h/%h/%b exp=1/000/80/1", o_we, o_addr, o_data, auto_triggered);
        end
        for (int i = 1; i < 256; i++) send(16'h0000, 1'b0);
        n_cmp++; if ({o_addr, o_fd} !== {9'h0FF, 1'b1}) begin
            n_err++; $display("FAIL auto_last got=%h/%b exp=0ff/1", o_addr, o_fd);
        end
        pulse_idle();
        n_cmp++; if (read_index !== 1'b0) begin n_err++; $display("FAIL auto_flip got=%b exp=0", read_index); end
    endtask

    task automatic test_capture_disable();
        int wr;
        capture_en = 1'b0; trig_mode = TRIG_FREE;
        wr = 0;
        for (int i = 0; i < 100; i++) begin
            send(16'h0000, 1'b0);
            if (o_we) wr++;
        end
        n_cmp++; if ({wr, armed, auto_triggered} !== {32'd0, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL cen_hold got=%0d/%b/%b exp=0/1/1", wr, armed, auto_triggered);
        end
        // Timeout must have stayed at 0: 13 more non-crossing samples may not fire.
        capture_en = 1'b1; trig_mode = TRIG_RISE; trig_level = 16'sd100;
        wr = 0;
        for (int i = 0; i < 13; i++) begin
            send(16'h0000, 1'b0);
            if (o_we) wr++;
        end
        n_cmp++; if (wr !== 0) begin n_err++; $display("FAIL cen_timeout_held got=%0d exp=0", wr); end
        trig_level = 16'sd0;
        send(16'hFFFB, 1'b0);
        send(16'h0003, 1'b0);
        n_cmp++; if ({o_we, o_addr, o_data, auto_triggered} !== {1'b1, 9'h100, 8'h80, 1'b0}) begin
            n_err++; $display("FAIL cen_natural got=%b/%h/%h/%b exp=1/100/80/0", o_we, o_addr, o_data, auto_triggered);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 1; i <= 100; i++) send(16'h1000, 1'b0);
        n_cmp++; if ({o_we, o_addr, o_data} !== {1'b1, 9'h164, 8'h90}) begin
            n_err++; $display("FAIL mid_idx100 got=%b/%h/%h exp=1/164/90", o_we, o_addr, o_data);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.write_enable, bus.write_address, bus.write_sample, read_index, frame_done, auto_triggered, armed}
            !== {1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL mid_reset got=%b/%h/%h/%b%b%b%b exp=0/000/00/0001", bus.write_enable,
                              bus.write_address, bus.write_sample, read_index, frame_done, auto_triggered, armed);
        end
        n_cmp++; if (state_dbg !== ST_ARMED) begin n_err++; $display("FAIL mid_state got=%b exp=00", state_dbg); end
        @(negedge clk);
        reset_n = 1'b1;
        send(16'hFFFB, 1'b0);
        send(16'h0003, 1'b0);
        n_cmp++; if ({o_we, o_addr, o_data} !== {1'b1, 9'h100, 8'h80}) begin
            n_err++; $display("FAIL mid_restart got=%b/%h/%h exp=1/100/80", o_we, o_addr, o_data);
        end
        // Finish the frame ending on -5 so the WAIT test starts with prev below level.
        for (int i = 1; i < 256; i++) send((i == 255) ? 16'hFFFB : 16'h0000, 1'b0);
        n_cmp++; if ({o_addr, o_fd, state_dbg} !== {9'h1FF, 1'b1, ST_WAIT}) begin
            n_err++; $display("FAIL mid_frame_end got=%h/%b/%b exp=1ff/1/10", o_addr, o_fd, state_dbg);
        end
    endtask

    task automatic test_wait_idle_same_cycle();
        send(16'h0003, 1'b1);
        n_cmp++; if ({o_we, armed, read_index} !== 3'b011) begin
            n_err++; $display("FAIL wait_idle_sample got=%b exp=011", {o_we, armed, read_index});
        end
        send(16'hFFFB, 1'b0);
        n_cmp++; if (o_we !== 1'b0) begin n_err++; $display("FAIL wait_below got=%b exp=0", o_we); end
        send(16'h0003, 1'b0);
        n_cmp++; if ({o_we, o_addr, o_data} !== {1'b1, 9'h000, 8'h80}) begin
            n_err++; $display("FAIL wait_cross got=%b/%h/%h exp=1/000/80", o_we, o_addr, o_data);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.new_sample_ready = 1'b0;
        bus.new_sample_in    = '0;
        wave_display_idle    = 1'b0;
        capture_en           = 1'b1;
        trig_mode            = TRIG_RISE;
        trig_level           = '0;
        decim                = '0;
        o_we = 1'b0; o_fd = 1'b0; o_addr = '0; o_data = '0;

        test_reset();
        test_rising();
        test_falling();
        test_decim();
        test_auto_timeout();
        test_capture_disable();
        test_reset_mid_frame();
        test_wait_idle_same_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
